// File: rtl/day_11_cnt_pkg.sv
// Shared definitions for the parametrised loadable counter.
//   MODE_* : end-of-range behaviour selectors for the MODE parameter
//   os_state_e : one-shot run state encoding
package day_11_cnt_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int MODE_ONESHOT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } os_state_e;

endpackage

// File: rtl/day_11_param_counter_load_next.sv
// Combinational next-value / end-of-range unit for the loadable counter.
//   count      : current registered count (always <= MAX_VAL)
//   up_dn      : 1 = count up, 0 = count down
//   en         : step request for this cycle
//   next_count : value to register when stepping
//   at_term    : count sits at the terminal value for the current direction
//   evt        : end-of-range event (en while at terminal)
module day_11_param_counter_load_next
  import day_11_cnt_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 1,
  parameter int              MODE    = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             en,
  output logic [WIDTH-1:0] next_count,
  output logic             at_term,
  output logic             evt
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  always_comb begin
    inc = {1'b0, count} + 1'b1;
    dec = {1'b0, count} - 1'b1;
    // Up: terminal when one more step would pass MAX_VAL.
    // Down: terminal when the decrement borrows into the extra bit.
    at_term = up_dn ? (inc > MAX_EXT) : dec[WIDTH];
    evt     = en && at_term;

    next_count = count;
    if (en) begin
      if (!at_term) begin
        next_count = up_dn ? inc[WIDTH-1:0] : dec[WIDTH-1:0];
      end else if (MODE == MODE_WRAP) begin
        next_count = up_dn ? '0 : MAX_W;
      end
    end
  end

endmodule

// File: rtl/day_11_param_counter_load.sv
// Parametrised loadable up/down counter with wrap / saturate / one-shot
// end-of-range handling and terminal-count, wrap and sticky overflow status.
//   clk, reset  : clock, synchronous active-high reset
//   en_i        : count enable
//   load_i      : load strobe (clamped to MAX_VAL), overrides en_i
//   load_val_i  : value to load
//   up_dn_i     : direction, 1 = up
//   clr_flags_i : clears sticky ovf_o (a same-cycle set wins)
//   count_o     : registered count
//   tc_o        : combinational terminal count for the current direction
//   wrap_o      : registered one-cycle end-of-range pulse
//   ovf_o       : sticky overflow (end-of-range or clamped load)
//   busy_o      : registered one-shot RUN indicator
//
// One-shot states (MODE_ONESHOT only; other modes stay in IDLE):
//   state   | meaning
//   IDLE    | waiting for first load, en_i ignored
//   RUN     | counting on en_i, busy_o high
//   DONE    | terminal reached, count frozen until next load
module day_11_param_counter_load
  import day_11_cnt_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 1,
  parameter int              MODE      = MODE_WRAP,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_dn_i,
  input  logic             clr_flags_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             ovf_o,
  output logic             busy_o
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_chk_width
    $error("WIDTH must be in 2..32");
  end
  if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 1)) begin : g_chk_max
    $error("MAX_VAL must be in 1..2**WIDTH-1");
  end
  if (RESET_VAL > MAX_VAL) begin : g_chk_rst
    $error("RESET_VAL must not exceed MAX_VAL");
  end
  if (MODE < MODE_WRAP || MODE > MODE_ONESHOT) begin : g_chk_mode
    $error("MODE must be 0, 1 or 2");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] next_count;
  logic             at_term;
  logic             step_evt;
  logic             wrap_q;
  logic             ovf_q;
  logic             busy_q;
  os_state_e        state_q;

  logic             en_eff;
  logic             evt;
  logic             load_over;
  logic [WIDTH-1:0] load_clamped;

  // In one-shot mode the enable only counts while running.
  assign en_eff = en_i && !load_i && ((MODE != MODE_ONESHOT) || (state_q == ST_RUN));

  day_11_param_counter_load_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .MODE    (MODE)
  ) u_next (
    .count      (count_q),
    .up_dn      (up_dn_i),
    .en         (en_eff),
    .next_count (next_count),
    .at_term    (at_term),
    .evt        (step_evt)
  );

  assign evt          = step_evt;
  assign load_over    = load_val_i > MAX_W;
  assign load_clamped = load_over ? MAX_W : load_val_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_W;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      if (load_i) begin
        count_q <= load_clamped;
      end else if (en_eff) begin
        count_q <= next_count;
      end
      wrap_q <= evt;
      // Set has priority over a same-cycle clear.
      ovf_q  <= (load_i && load_over) || evt || (ovf_q && !clr_flags_i);

      if (MODE == MODE_ONESHOT) begin
        case (state_q)
          ST_IDLE: if (load_i) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
          ST_RUN: if (evt) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
          end
          ST_DONE: if (load_i) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_o = count_q;
  assign tc_o    = at_term;
  assign wrap_o  = wrap_q;
  assign ovf_o   = ovf_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_day_11_param_counter_load.sv
module tb_day_11_param_counter_load;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst   [N];
  logic       en    [N];
  logic       ld    [N];
  logic [3:0] lv    [N];
  logic       up    [N];
  logic       clr   [N];
  logic [3:0] count [N];
  logic       tc    [N];
  logic       wrap  [N];
  logic       ovf   [N];
  logic       busy  [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    day_11_param_counter_load #(
      .WIDTH     (4),
      .MAX_VAL   (9),
      .MODE      (g),
      .RESET_VAL (0)
    ) dut (
      .clk         (clk),
      .reset       (rst[g]),
      .en_i        (en[g]),
      .load_i      (ld[g]),
      .load_val_i  (lv[g]),
      .up_dn_i     (up[g]),
      .clr_flags_i (clr[g]),
      .count_o     (count[g]),
      .tc_o        (tc[g]),
      .wrap_o      (wrap[g]),
      .ovf_o       (ovf[g]),
      .busy_o      (busy[g])
    );
  end

  typedef struct {
    int    m;
    int    cnt;
    bit    up;
    bit    wrp;
    bit    ov;
    bit    bsy;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input int m, input bit r, input bit l, input int v,
                       input bit e, input bit u, input bit c,
                       input int ecnt, input bit ew, input bit eo, input bit eb,
                       input string tag);
    exp_t x;
    rst[m] = r; ld[m] = l; lv[m] = 4'(v); en[m] = e; up[m] = u; clr[m] = c;
    x.m = m; x.cnt = ecnt; x.up = u; x.wrp = ew; x.ov = eo; x.bsy = eb; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic tick();
    exp_t x;
    logic [3:0] ec;
    logic       etc;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      ec  = 4'(x.cnt);
      etc = x.up ? (x.cnt == 9) : (x.cnt == 0);
      checks++;
      assert (count[x.m] === ec) else begin
        errors++;
        $error("FAIL %s count got %0d exp %0d", x.tag, count[x.m], ec);
      end
      checks++;
      assert (tc[x.m] === etc) else begin
        errors++;
        $error("FAIL %s tc got %0b exp %0b", x.tag, tc[x.m], etc);
      end
      checks++;
      assert (wrap[x.m] === x.wrp) else begin
        errors++;
        $error("FAIL %s wrap got %0b exp %0b", x.tag, wrap[x.m], x.wrp);
      end
      checks++;
      assert (ovf[x.m] === x.ov) else begin
        errors++;
        $error("FAIL %s ovf got %0b exp %0b", x.tag, ovf[x.m], x.ov);
      end
      checks++;
      assert (busy[x.m] === x.bsy) else begin
        errors++;
        $error("FAIL %s busy got %0b exp %0b", x.tag, busy[x.m], x.bsy);
      end
    end
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0; ld[i] = 1'b0; en[i] = 1'b0; clr[i] = 1'b0;
    end
  endtask

  task automatic step(input int m, input bit r, input bit l, input int v,
                      input bit e, input bit u, input bit c,
                      input int ecnt, input bit ew, input bit eo, input bit eb,
                      input string tag);
    drive(m, r, l, v, e, u, c, ecnt, ew, eo, eb, tag);
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0; ld[i] = 1'b0; lv[i] = '0; en[i] = 1'b0; up[i] = 1'b0; clr[i] = 1'b0;
    end

    // Reset all three instances, with enable active to prove reset wins.
    for (int i = 0; i < N; i++)
      drive(i, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, $sformatf("rst_m%0d", i));
    tick();

    // MODE 0: up from reset, wrap 9 -> 0.
    for (int k = 1; k <= 9; k++)
      step(0, 0, 0, 0, 1, 1, 0, k, 0, 0, 0, $sformatf("m0_up%0d", k));
    step(0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, "m0_wrap");
    step(0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, "m0_after_wrap");
    step(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, "m0_hold");
    step(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, "m0_clr");

    // MODE 0: down from load 2, wrap 0 -> 9.
    step(0, 0, 1, 2, 0, 0, 0, 2, 0, 0, 0, "m0_ld2");
    step(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, "m0_dn1");
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "m0_dn0");
    step(0, 0, 0, 0, 1, 0, 0, 9, 1, 1, 0, "m0_dnwrap");
    step(0, 0, 0, 0, 1, 0, 0, 8, 0, 1, 0, "m0_dn8");

    // MODE 0: clamped load with concurrent enable.
    step(0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, "m0_clr2");
    step(0, 0, 1, 13, 1, 1, 0, 9, 0, 1, 0, "m0_ld13");

    // MODE 0: clear and wrap event in the same cycle -> set wins.
    step(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, "m0_ld0_clr");
    step(0, 0, 0, 0, 1, 0, 1, 9, 1, 1, 0, "m0_clr_vs_evt");

    // MODE 1: saturate at 9, re-pulse wrap, then count down.
    step(1, 0, 1, 7, 1, 1, 0, 7, 0, 0, 0, "m1_ld7");
    step(1, 0, 0, 0, 1, 1, 0, 8, 0, 0, 0, "m1_up8");
    step(1, 0, 0, 0, 1, 1, 0, 9, 0, 0, 0, "m1_up9");
    step(1, 0, 0, 0, 1, 1, 0, 9, 1, 1, 0, "m1_sat_a");
    step(1, 0, 0, 0, 1, 1, 0, 9, 1, 1, 0, "m1_sat_b");
    step(1, 0, 0, 0, 1, 0, 0, 8, 0, 1, 0, "m1_dn8");
    step(1, 0, 0, 0, 1, 1, 0, 9, 0, 1, 0, "m1_up9b");
    step(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, "m1_rst_at_term");

    // MODE 2: one-shot sequence.
    step(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, "m2_idle_en_a");
    step(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, "m2_idle_en_b");
    step(2, 0, 1, 7, 0, 1, 0, 7, 0, 0, 1, "m2_ld7");
    step(2, 0, 0, 0, 1, 1, 0, 8, 0, 0, 1, "m2_run8");
    step(2, 0, 0, 0, 1, 1, 0, 9, 0, 0, 1, "m2_run9");
    step(2, 0, 0, 0, 1, 1, 0, 9, 1, 1, 0, "m2_done");
    step(2, 0, 0, 0, 1, 1, 0, 9, 0, 1, 0, "m2_done_hold");
    step(2, 0, 1, 3, 0, 1, 0, 3, 0, 1, 1, "m2_reld3");
    step(2, 0, 0, 0, 1, 1, 0, 4, 0, 1, 1, "m2_run4");
    step(2, 0, 0, 0, 1, 1, 0, 5, 0, 1, 1, "m2_run5");
    step(2, 1, 1, 7, 1, 1, 0, 0, 0, 0, 0, "m2_rst_midrun");
    step(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, "m2_idle_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
